// File: rtl/exp2_lut_pipe.sv
// exp2_lut_pipe: float32 2^x or e^x from a signed fixed-point exponent, interpolated LUT; 4-cycle latency, 1 result/cycle.
// Backpressure: all four stages freeze together while out_valid && !out_ready; in_ready is that advance term.
module exp2_lut_pipe #(
   parameter int IN_W     = 24,
   parameter int FRAC_W   = 16,
   parameter int LUT_BITS = 8,
   parameter int TAG_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_x,
   input  logic              in_base_e,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_ovf,
   output logic              out_unf,
   input  logic              clr_cnt,
   output logic [15:0]       ovf_cnt,
   output logic [15:0]       unf_cnt
);

   localparam int Y_W    = IN_W + 2;
   localparam int P_W    = IN_W + 18;
   localparam int K_FRAC = 16;
   localparam int N_W    = Y_W - FRAC_W;
   localparam int R_W    = FRAC_W - LUT_BITS;
   localparam int LUT_N  = (1 << LUT_BITS) + 1;
   localparam int L_W    = 25;
   localparam int E_W    = N_W + 2;
   localparam logic signed [P_W-1:0] LOG2E = P_W'(94548);

   typedef struct packed {
      logic [Y_W-1:0]   y;
      logic [TAG_W-1:0] tag;
   } s1_t;

   typedef struct packed {
      logic [N_W-1:0]   n;
      logic [L_W-1:0]   lo;
      logic [L_W-1:0]   hi;
      logic [R_W-1:0]   r;
      logic [TAG_W-1:0] tag;
   } s2_t;

   typedef struct packed {
      logic [N_W-1:0]   n;
      logic [22:0]      mant;
      logic [TAG_W-1:0] tag;
   } s3_t;

   // Mantissa table L[i] = round(2^(23 + i/2^LUT_BITS)), last entry is exactly 2^24.
   logic [L_W-1:0] lut [LUT_N];
   for (genvar g = 0; g < LUT_N; g++) begin : g_lut
      localparam int LV = $rtoi(2.0 ** (23.0 + real'(g) / real'(2 ** LUT_BITS)) + 0.5);
      assign lut[g] = LV[L_W-1:0];
   end

   logic advance;
   assign advance  = out_ready || !out_valid;
   assign in_ready = advance;

   logic s1_vld, s2_vld, s3_vld;
   s1_t  s1_q, s1_d;
   s2_t  s2_q, s2_d;
   s3_t  s3_q, s3_d;

   // S1: e^x is 2^(x*log2e); the product is floored back to the input's fraction scale.
   logic signed [P_W-1:0] x_ext, prod;
   assign x_ext = P_W'($signed(in_x));
   assign prod  = x_ext * LOG2E;
   always_comb begin
      s1_d     = '0;
      s1_d.tag = in_tag;
      s1_d.y   = in_base_e ? Y_W'(prod >>> K_FRAC) : Y_W'($signed(in_x));
   end

   logic [LUT_BITS:0] idx_lo, idx_hi;
   assign idx_lo = {1'b0, s1_q.y[FRAC_W-1 -: LUT_BITS]};
   assign idx_hi = idx_lo + (LUT_BITS + 1)'(1);
   always_comb begin
      s2_d     = '0;
      s2_d.n   = s1_q.y[Y_W-1 -: N_W];
      s2_d.lo  = lut[idx_lo];
      s2_d.hi  = lut[idx_hi];
      s2_d.r   = s1_q.y[R_W-1:0];
      s2_d.tag = s1_q.tag;
   end

   // Only the 23 stored mantissa bits survive; the hidden one is implied by m >= 2^23.
   always_comb begin
      s3_d      = '0;
      s3_d.n    = s2_q.n;
      s3_d.tag  = s2_q.tag;
      s3_d.mant = 23'(s2_q.lo + L_W'(((L_W + R_W)'(s2_q.hi - s2_q.lo)
                                      * (L_W + R_W)'(s2_q.r)) >> R_W));
   end

   logic signed [E_W-1:0] e_b;
   logic                  ovf_d, unf_d;
   logic [31:0]           data_d;
   assign e_b   = E_W'($signed(s3_q.n)) + E_W'(127);
   assign ovf_d = (e_b >= E_W'(255));
   assign unf_d = (e_b <= E_W'(0));
   always_comb begin
      data_d = {1'b0, e_b[7:0], s3_q.mant};
      if (ovf_d)      data_d = 32'h7F80_0000;
      else if (unf_d) data_d = 32'h0000_0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld    <= 1'b0;
         s2_vld    <= 1'b0;
         s3_vld    <= 1'b0;
         s1_q      <= '0;
         s2_q      <= '0;
         s3_q      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_ovf   <= 1'b0;
         out_unf   <= 1'b0;
      end else if (advance) begin
         s1_vld    <= in_valid;
         s2_vld    <= s1_vld;
         s3_vld    <= s2_vld;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         s3_q      <= s3_d;
         out_valid <= s3_vld;
         out_data  <= data_d;
         out_tag   <= s3_q.tag;
         out_ovf   <= ovf_d;
         out_unf   <= unf_d;
      end
   end

   logic acc;
   assign acc = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt <= '0;
         unf_cnt <= '0;
      end else if (clr_cnt) begin
         ovf_cnt <= '0;
         unf_cnt <= '0;
      end else begin
         if (acc && out_ovf && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
         if (acc && out_unf && unf_cnt != 16'hFFFF) unf_cnt <= unf_cnt + 16'd1;
      end
   end

endmodule
